// File: rtl/clock_set_controller.sv
// Button front end for the VGA clock: synchronise, debounce, arbitrate hour/min/sec, auto-repeat strobes.
// Optional feature macro: CLOCK_SET_FAST_REPEAT_EN (faster repeat after 8 repeat strobes in one hold).
module clock_set_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hour_in,
    input  logic min_in,
    input  logic sec_in,
    input  logic al_in,
    input  logic al_on_off_toggle_in,
    output logic inc_hour_o,
    output logic inc_min_o,
    output logic clr_sec_o,
    output logic sel_alarm_o,
    output logic alarm_en_o
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
`ifdef CLOCK_SET_FAST_REPEAT_EN
    localparam int FAST_RATE = (REPEAT_RATE / 4 > 0) ? REPEAT_RATE / 4 : 1;
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_RATE - 1);
`endif

    localparam int B_HOUR = 0;
    localparam int B_MIN  = 1;
    localparam int B_SEC  = 2;
    localparam int B_TOG  = 3;
    localparam int B_AL   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD_WAIT,
        S_REPEAT,
        S_WAIT_RELEASE
    } state_t;

    logic [4:0]       w_raw;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [4:0]       r_deb;
    logic [4:0]       r_vld;
    logic [3:0]       r_deb_d;
    logic [3:0]       r_vld_d;
    logic [CNT_W-1:0] r_db_cnt [0:4];
    logic [3:0]       w_rise;
    logic             w_held;
    logic [CNT_W-1:0] w_rate_last;

    state_t           r_state;
    logic [2:0]       r_btn;
    logic [CNT_W-1:0] r_rep_cnt;
`ifdef CLOCK_SET_FAST_REPEAT_EN
    logic [3:0]       r_fast_cnt;
`endif

    assign w_raw = {al_in, al_on_off_toggle_in, sec_in, min_in, hour_in};

    // After reset a level must first be seen stable (r_vld) before its edges count, so a
    // button held through reset cannot fire until it is released and pressed again.
    assign w_rise = r_deb[3:0] & ~r_deb_d & r_vld_d;
    assign w_held = |(r_btn & r_deb[2:0]);

`ifdef CLOCK_SET_FAST_REPEAT_EN
    assign w_rate_last = (r_fast_cnt == 4'd8) ? FAST_LAST : RATE_LAST;
`else
    assign w_rate_last = RATE_LAST;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_vld   <= '0;
            r_deb_d <= '0;
            r_vld_d <= '0;
            for (int i = 0; i < 5; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb[3:0];
            r_vld_d <= r_vld[3:0];
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    if (r_vld[i]) begin
                        r_db_cnt[i] <= '0;
                    end else if (r_db_cnt[i] >= DB_LAST) begin
                        r_vld[i]    <= 1'b1;
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else if (!r_vld[i]) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] >= DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_en_o <= 1'b0;
        end else if (w_rise[B_TOG]) begin
            alarm_en_o <= ~alarm_en_o;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_btn       <= '0;
            r_rep_cnt   <= '0;
            inc_hour_o  <= 1'b0;
            inc_min_o   <= 1'b0;
            clr_sec_o   <= 1'b0;
            sel_alarm_o <= 1'b0;
`ifdef CLOCK_SET_FAST_REPEAT_EN
            r_fast_cnt  <= '0;
`endif
        end else begin
            inc_hour_o <= 1'b0;
            inc_min_o  <= 1'b0;
            clr_sec_o  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise[B_HOUR]) begin
                        r_btn       <= 3'b001;
                        sel_alarm_o <= r_deb[B_AL];
                        inc_hour_o  <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_state     <= S_HOLD_WAIT;
                    end else if (w_rise[B_MIN]) begin
                        r_btn       <= 3'b010;
                        sel_alarm_o <= r_deb[B_AL];
                        inc_min_o   <= 1'b1;
                        r_rep_cnt   <= '0;
                        r_state     <= S_HOLD_WAIT;
                    end else if (w_rise[B_SEC]) begin
                        r_btn       <= 3'b100;
                        sel_alarm_o <= r_deb[B_AL];
                        clr_sec_o   <= ~r_deb[B_AL];
                        r_state     <= S_WAIT_RELEASE;
                    end
                end
                S_HOLD_WAIT: begin
                    if (!w_held) begin
                        r_state <= S_IDLE;
                    end else if (r_rep_cnt >= DELAY_LAST) begin
                        inc_hour_o <= r_btn[B_HOUR];
                        inc_min_o  <= r_btn[B_MIN];
                        r_rep_cnt  <= '0;
                        r_state    <= S_REPEAT;
`ifdef CLOCK_SET_FAST_REPEAT_EN
                        r_fast_cnt <= '0;
`endif
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!w_held) begin
                        r_state <= S_IDLE;
                    end else if (r_rep_cnt >= w_rate_last) begin
                        inc_hour_o <= r_btn[B_HOUR];
                        inc_min_o  <= r_btn[B_MIN];
                        r_rep_cnt  <= '0;
`ifdef CLOCK_SET_FAST_REPEAT_EN
                        if (r_fast_cnt != 4'd8) begin
                            r_fast_cnt <= r_fast_cnt + 1'b1;
                        end
`endif
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!w_held) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short debounce/repeat parameters.
module tb_clock_set_controller;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int GAP = 15;

    logic clk = 1'b0;
    logic reset_n;
    logic hour_in, min_in, sec_in, al_in, al_on_off_toggle_in;
    logic inc_hour_o, inc_min_o, clr_sec_o, sel_alarm_o, alarm_en_o;

    clock_set_controller #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .hour_in            (hour_in),
        .min_in             (min_in),
        .sec_in             (sec_in),
        .al_in              (al_in),
        .al_on_off_toggle_in(al_on_off_toggle_in),
        .inc_hour_o         (inc_hour_o),
        .inc_min_o          (inc_min_o),
        .clr_sec_o          (clr_sec_o),
        .sel_alarm_o        (sel_alarm_o),
        .alarm_en_o         (alarm_en_o)
    );

    always #5 clk = ~clk;

    // btn bits: [0] hour, [1] min, [2] sec, [3] al, [4] alarm toggle
    typedef struct {
        logic [4:0] btn;
        int         hold;
        int         eh;
        int         em;
        int         es;
        logic       sel;
        logic       en;
    } vec_t;

    vec_t tbl [12];

    int   errors = 0;
    int   checks = 0;
    int   it;
    int   n_h, n_m, n_s, sel_bad, multi;
    int   h_times[$];
    int   m_times[$];
    logic exp_sel_g;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        it = 0; n_h = 0; n_m = 0; n_s = 0; sel_bad = 0; multi = 0;
        h_times.delete();
        m_times.delete();
    endtask

    // One cycle: sample outputs registered at the last rising edge, then drive this cycle's inputs.
    task automatic cyc(input logic [4:0] b);
        @(negedge clk);
        if (inc_hour_o) begin n_h++; h_times.push_back(it); end
        if (inc_min_o)  begin n_m++; m_times.push_back(it); end
        if (clr_sec_o)  n_s++;
        if ((inc_hour_o || inc_min_o) && (sel_alarm_o !== exp_sel_g)) sel_bad++;
        if ((int'(inc_hour_o) + int'(inc_min_o) + int'(clr_sec_o)) > 1) multi++;
        hour_in             = b[0];
        min_in              = b[1];
        sec_in              = b[2];
        al_in               = b[3];
        al_on_off_toggle_in = b[4];
        it++;
    endtask

    task automatic run(input logic [4:0] b, input int n);
        for (int k = 0; k < n; k++) cyc(b);
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{5'b00001, 10, 1, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{5'b00010, 30, 0, 3, 0, 1'b0, 1'b0};
        tbl[2]  = '{5'b00100, 10, 0, 0, 1, 1'b0, 1'b0};
        tbl[3]  = '{5'b01100, 10, 0, 0, 0, 1'b1, 1'b0};
        tbl[4]  = '{5'b01001, 10, 1, 0, 0, 1'b1, 1'b0};
        tbl[5]  = '{5'b01010, 40, 0, 5, 0, 1'b1, 1'b0};
        tbl[6]  = '{5'b10000, 15, 0, 0, 0, 1'b0, 1'b1};
        tbl[7]  = '{5'b10000, 15, 0, 0, 0, 1'b0, 1'b0};
        tbl[8]  = '{5'b10000, 15, 0, 0, 0, 1'b0, 1'b1};
        tbl[9]  = '{5'b10000,  3, 0, 0, 0, 1'b0, 1'b1};
        tbl[10] = '{5'b00001,  3, 0, 0, 0, 1'b0, 1'b1};
        tbl[11] = '{5'b00011, 10, 1, 0, 0, 1'b0, 1'b1};

        reset_n = 1'b0;
        hour_in = 0; min_in = 0; sec_in = 0; al_in = 0; al_on_off_toggle_in = 0;
        exp_sel_g = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_inc_hour", inc_hour_o, 0);
        check("reset_inc_min", inc_min_o, 0);
        check("reset_clr_sec", clr_sec_o, 0);
        check("reset_sel", sel_alarm_o, 0);
        check("reset_alarm_en", alarm_en_o, 0);
        reset_n = 1'b1;
        clear_stats();
        run(5'b00000, 12);

        // Single press: one strobe at cycle 7, nothing after release
        clear_stats();
        run(5'b00001, 10);
        run(5'b00000, 20);
        check("t1_hour_count", n_h, 1);
        check("t1_hour_time", qget(h_times, 0), 7);
        check("t1_sel", sel_bad, 0);

        // Bounce then hold: last rising edge at cycle 12, release at cycle 52
        clear_stats();
        for (int i = 0; i < 12; i++) cyc(((i % 4) < 2) ? 5'b00010 : 5'b00000);
        run(5'b00010, 40);
        run(5'b00000, 20);
        check("t2_min_count", n_m, 5);
        check("t2_min_t0", qget(m_times, 0), 19);
        check("t2_min_t1", qget(m_times, 1), 39);
        check("t2_min_t2", qget(m_times, 2), 44);
        check("t2_min_t3", qget(m_times, 3), 49);
        check("t2_min_t4", qget(m_times, 4), 54);

        // Gesture table: press for hold cycles, release for GAP cycles
        for (int r = 0; r < 12; r++) begin
            clear_stats();
            exp_sel_g = tbl[r].sel;
            run(tbl[r].btn, tbl[r].hold);
            run(5'b00000, GAP);
            check($sformatf("v%0d_hour", r), n_h, tbl[r].eh);
            check($sformatf("v%0d_min", r), n_m, tbl[r].em);
            check($sformatf("v%0d_sec", r), n_s, tbl[r].es);
            check($sformatf("v%0d_sel", r), sel_bad, 0);
            check($sformatf("v%0d_onehot", r), multi, 0);
            check($sformatf("v%0d_alarm_en", r), alarm_en_o, tbl[r].en);
        end

        // al held at hour press, released mid-hold: target stays alarm
        clear_stats();
        exp_sel_g = 1'b1;
        run(5'b01000, 5);
        run(5'b01001, 15);
        run(5'b00001, 25);
        run(5'b00000, 20);
        check("t3_hour_count", n_h, 5);
        check("t3_hour_t0", qget(h_times, 0), 12);
        check("t3_sel", sel_bad, 0);

        // hour+min together; min still held after hour release must not fire
        clear_stats();
        exp_sel_g = 1'b0;
        run(5'b00011, 12);
        run(5'b00010, 28);
        run(5'b00000, 15);
        check("t4_hour_count", n_h, 1);
        check("t4_min_held", n_m, 0);
        run(5'b00010, 10);
        run(5'b00000, 15);
        check("t4_min_repress", n_m, 1);
        check("t4_min_time", qget(m_times, 0), 62);
        check("t4_onehot", multi, 0);

        // Long hold into repeat, then asynchronous reset mid-hold
        clear_stats();
        run(5'b00001, 72);
`ifdef CLOCK_SET_FAST_REPEAT_EN
        check("t6_hour_count", n_h, 14);
        check("t6_fast_t10", qget(h_times, 10), 68);
        check("t6_fast_t11", qget(h_times, 11), 69);
`else
        check("t6_hour_count", n_h, 10);
        check("t6_rep_t9", qget(h_times, 9), 67);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_inc_hour", inc_hour_o, 0);
        check("t6_rst_inc_min", inc_min_o, 0);
        check("t6_rst_clr_sec", clr_sec_o, 0);
        check("t6_rst_sel", sel_alarm_o, 0);
        check("t6_rst_alarm_en", alarm_en_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        run(5'b00001, 30);
        check("t6_held_after_reset", n_h, 0);
        run(5'b00000, 15);
        run(5'b00001, 10);
        run(5'b00000, 15);
        check("t6_repress_count", n_h, 1);
        check("t6_repress_time", qget(h_times, 0), 52);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
